cache_fill_arbiter: RTL

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_pkg.sv | 19 +
 rtl/word_counter.sv | 22 ++
 rtl/cache_fill_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM/owner types and block geometry for the cache fill arbiter
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int BLOCK_OFFSET_W  = $clog2(2 * WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } fill_state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/word_counter.sv
// rtl/word_counter.sv - word index counter with synchronous clear and increment
module word_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WORD_IDX_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - arbitrates I/D cache misses onto one memory read port and steers block fills
module cache_fill_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               I_miss,
    input  logic [ADDR_W-1:0]                  I_miss_addr,
    input  logic                               D_miss,
    input  logic [ADDR_W-1:0]                  D_miss_addr,
    input  logic                               mem_data_valid,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               I_fill_we,
    output logic                               D_fill_we,
    output logic                               I_tag_we,
    output logic                               D_tag_we,
    output logic                               busy
);
    import cache_pkg::*;

    localparam int                    OFFSET_W   = $clog2(2 * WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0]     BLOCK_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD  = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

    fill_state_e           state, state_nxt;
    owner_e                owner, owner_nxt;
    logic [ADDR_W-1:0]     base, base_nxt;
    logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt;
    logic                  fill, done;

    // Memory latency is a property of the memory; returns are simply counted.
    logic [31:0] unused_mem_lat;
    assign unused_mem_lat = MEM_LAT;

    assign fill      = (state != ST_IDLE) && mem_data_valid;
    assign done      = fill && (recv_cnt == LAST_WORD);
    assign mem_en    = (state == ST_ISSUE);
    assign mem_addr  = mem_en ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
    assign fill_word = fill ? recv_cnt : '0;
    assign I_fill_we = fill && (owner == OWN_I);
    assign D_fill_we = fill && (owner == OWN_D);
    assign I_tag_we  = done && (owner == OWN_I);
    assign D_tag_we  = done && (owner == OWN_D);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWN_D;
            base  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            base  <= base_nxt;
        end
    end

    // D wins ties because it belongs to the older instruction; no preemption once busy.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        base_nxt  = base;
        case (state)
            ST_IDLE: begin
                if (D_miss) begin
                    state_nxt = ST_ISSUE;
                    owner_nxt = OWN_D;
                    base_nxt  = D_miss_addr & BLOCK_MASK;
                end else if (I_miss) begin
                    state_nxt = ST_ISSUE;
                    owner_nxt = OWN_I;
                    base_nxt  = I_miss_addr & BLOCK_MASK;
                end
            end
            ST_ISSUE: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end else if (issue_cnt == LAST_WORD) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    word_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (done),
        .inc   (mem_en),
        .count (issue_cnt)
    );

    word_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (done),
        .inc   (fill),
        .count (recv_cnt)
    );

endmodule
